amp_bridge_ctrl: RTL

Sequencing controller for the amplifier's complementary PWM bridge. It gates the duty word fed to the pwm block with a soft-start ramp. It converts the raw single-ended PWM level into two non-overlapping gate drives with programmable dead-time. It latches external faults into a safe all-off state until software clears them. Sits between the triangle/duty source and the pwm block, and drives pwm_out_A/pwm_out_B and the LEDs in place of the plain inverter.

---
 rtl/amp_ctrl_pkg.sv | 17 +
 rtl/deadtime_gen.sv | 58 +++++
 rtl/amp_bridge_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/amp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : amp_ctrl_pkg
// Purpose  : Shared state encoding for the amplifier bridge controller.
// Revision : 1.0
// ============================================================================
package amp_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module   : deadtime_gen
// Purpose  : Splits a single-ended PWM level into non-overlapping gate drives.
// Revision : 1.0
// ============================================================================
module deadtime_gen #(
    parameter int DEAD_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic load,
    input  logic pwm_in,
    output logic out_a,
    output logic out_b
);

    localparam int DT_W = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam logic [DT_W-1:0] C_DT_LOAD = DT_W'(DEAD_TICKS);
    localparam logic [DT_W-1:0] C_DT_ONE  = DT_W'(1);

    logic            r_p;
    logic [DT_W-1:0] r_dt;

    // Every path except the settled one forces both gates low, so the
    // two outputs can never be high together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p   <= 1'b0;
            r_dt  <= '0;
            out_a <= 1'b0;
            out_b <= 1'b0;
        end else if (load) begin
            r_p   <= pwm_in;
            r_dt  <= C_DT_LOAD;
            out_a <= 1'b0;
            out_b <= 1'b0;
        end else if (!ena) begin
            out_a <= 1'b0;
            out_b <= 1'b0;
        end else if (pwm_in != r_p) begin
            r_p   <= pwm_in;
            r_dt  <= C_DT_LOAD;
            out_a <= 1'b0;
            out_b <= 1'b0;
        end else if (r_dt != '0) begin
            r_dt  <= r_dt - C_DT_ONE;
            out_a <= 1'b0;
            out_b <= 1'b0;
        end else begin
            out_a <= r_p;
            out_b <= ~r_p;
        end
    end

endmodule
`default_nettype wire

// File: rtl/amp_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : amp_bridge_ctrl
// Purpose  : Soft-start, dead-time and fault sequencing for the PWM bridge.
// Revision : 1.0
// ============================================================================
module amp_bridge_ctrl
    import amp_ctrl_pkg::*;
#(
    parameter int N          = 8,
    parameter int DEAD_TICKS = 4,
    parameter int RAMP_STEP  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic [N-1:0] duty_in,
    input  logic         pwm_in,
    input  logic         fault,
    input  logic         clear,
    output logic [N-1:0] duty_out,
    output logic         out_a,
    output logic         out_b,
    output logic [1:0]   state
);

    localparam logic [N-1:0] C_DUTY_MAX = '1;
    localparam logic [N:0]   C_STEP     = (N+1)'(RAMP_STEP);

    ctrl_state_t  r_state;
    logic [N-1:0] r_limit;
    logic [N:0]   w_sum;
    logic [N-1:0] w_limit_next;
    logic         w_active;
    logic         w_load;

    // Carry out of the widened sum means the limit would wrap; clamp instead.
    assign w_sum        = {1'b0, r_limit} + C_STEP;
    assign w_limit_next = w_sum[N] ? C_DUTY_MAX : w_sum[N-1:0];

    assign w_active = ((r_state == S_RAMP) || (r_state == S_RUN)) && ena && !fault;
    assign w_load   = (r_state == S_IDLE) && ena && !fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_limit  <= '0;
            duty_out <= '0;
        end else if (fault) begin
            r_state  <= S_FAULT;
            duty_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    duty_out <= '0;
                    if (ena) begin
                        r_state <= S_RAMP;
                        r_limit <= '0;
                    end
                end
                S_RAMP: begin
                    if (!ena) begin
                        r_state  <= S_IDLE;
                        duty_out <= '0;
                    end else begin
                        duty_out <= (duty_in < r_limit) ? duty_in : r_limit;
                        if (r_limit >= duty_in) r_state <= S_RUN;
                        if (step) r_limit <= w_limit_next;
                    end
                end
                S_RUN: begin
                    if (!ena) begin
                        r_state  <= S_IDLE;
                        duty_out <= '0;
                    end else begin
                        duty_out <= duty_in;
                    end
                end
                S_FAULT: begin
                    duty_out <= '0;
                    if (clear && !ena) r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    duty_out <= '0;
                end
            endcase
        end
    end

    assign state = r_state;

    deadtime_gen #(
        .DEAD_TICKS (DEAD_TICKS)
    ) u_deadtime (
        .clk    (clk),
        .rst    (rst),
        .ena    (w_active),
        .load   (w_load),
        .pwm_in (pwm_in),
        .out_a  (out_a),
        .out_b  (out_b)
    );

endmodule
`default_nettype wire
